// File: rtl/dmem_pkg.sv
// Shared constants for the data-side memory and MMIO block.
// Offsets, STATUS layout, reset values and the address decoder.
package dmem_pkg;

  localparam logic [15:0] OFF_TXDATA   = 16'h0000;
  localparam logic [15:0] OFF_STATUS   = 16'h0004;
  localparam logic [15:0] OFF_MTIME    = 16'h0008;
  localparam logic [15:0] OFF_MTIMECMP = 16'h000C;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_CNT   = 4;

  localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TXDATA,
    SEL_STATUS,
    SEL_MTIME,
    SEL_MTIMECMP,
    SEL_NONE
  } sel_e;

  function automatic sel_e decode(
    input logic        is_mmio,
    input logic [15:0] off
  );
    sel_e s;
    s = SEL_NONE;
    if (!is_mmio) begin
      s = SEL_RAM;
    end else begin
      unique case (off)
        OFF_TXDATA:   s = SEL_TXDATA;
        OFF_STATUS:   s = SEL_STATUS;
        OFF_MTIME:    s = SEL_MTIME;
        OFF_MTIMECMP: s = SEL_MTIMECMP;
        default:      s = SEL_NONE;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Small circular byte FIFO with simultaneous push/pop.
// Reports a drop when a push finds it full with no pop.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A pop frees a slot, so a push at full still lands.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM with byte-lane writes plus an MMIO window holding
// a free-running timer with compare IRQ and a TX byte FIFO.
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          is_mmio;
  logic [15:0]   off;
  sel_e          sel;

  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          drop;
  logic          ovf;
  logic          ovf_clr;

  logic [31:0]   mtime;
  logic [31:0]   mtimecmp;
  logic [31:0]   status;
  logic          unused_addr;

  assign is_mmio     = (addr[31:16] == MMIO_BASE[31:16]);
  assign off         = {addr[15:2], 2'b00};
  assign idx         = addr[AW+1:2];
  assign sel         = decode(is_mmio, off);
  assign unused_addr = ^addr[1:0];

  assign push    = we && (sel == SEL_TXDATA) && byte_en[0];
  assign pop     = tx_valid && tx_ready;
  assign ovf_clr = we && (sel == SEL_STATUS) && wdata[ST_OVF];

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wdata[7:0]),
    .pop       (pop),
    .head      (tx_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drop      (drop)
  );

  assign tx_valid = !empty;

  always_ff @(posedge clk) begin
    if (we && (sel == SEL_RAM)) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          ram[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // A drop wins over a same-cycle clear so no loss goes unreported.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mtime     <= '0;
      mtimecmp  <= MTIMECMP_RST;
      timer_irq <= 1'b0;
    end else begin
      if (we && (sel == SEL_MTIME)) begin
        mtime <= wdata;
      end else begin
        mtime <= mtime + 32'd1;
      end
      if (we && (sel == SEL_MTIMECMP)) begin
        mtimecmp <= wdata;
      end
      timer_irq <= (mtime >= mtimecmp);
    end
  end

  always_comb begin
    status             = '0;
    status[ST_FULL]    = full;
    status[ST_EMPTY]   = empty;
    status[ST_OVF]     = ovf;
    status[ST_CNT +: CW] = count;
  end

  always_comb begin
    rdata = '0;
    unique case (sel)
      SEL_RAM:      rdata = ram[idx];
      SEL_STATUS:   rdata = status;
      SEL_MTIME:    rdata = mtime;
      SEL_MTIMECMP: rdata = mtimecmp;
      default:      rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM lanes and aliasing,
// TX FIFO overflow and push/pop, timer wrap, compare and reset.
module tb_dmem_mmio;

  localparam logic [31:0] TXD  = 32'hFFFF_0000;
  localparam logic [31:0] STS  = 32'hFFFF_0004;
  localparam logic [31:0] MTM  = 32'hFFFF_0008;
  localparam logic [31:0] MCMP = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  int passed = 0;
  int total  = 0;

  dmem_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .byte_en   (byte_en),
    .rdata     (rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    addr    = a;
    wdata   = d;
    byte_en = be;
    we      = 1'b1;
    tick();
    we      = 1'b0;
    byte_en = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    we   = 1'b0;
    #1;
    v = rdata;
  endtask

  initial begin
    logic [31:0] v;
    logic        found;
    reset = 1'b0; addr = '0; wdata = '0;
    we = 1'b0; byte_en = 4'h0; tx_ready = 1'b0;
    tick();
    tick();
    rd(STS, v);  chk("rst_status", v, 32'h2);
    rd(MTM, v);  chk("rst_mtime", v, 32'h0);
    rd(MCMP, v); chk("rst_mtimecmp", v, 32'hFFFF_FFFF);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
    chk("rst_irq", {31'b0, timer_irq}, 32'h0);
    reset = 1'b1;

    wr(32'h10, 32'h1122_3344, 4'hF);
    wr(32'h10, 32'h00AA_0000, 4'b0100);
    rd(32'h10, v); chk("ram_lane", v, 32'h11AA_3344);
    rd(32'h10 + 32'd4096, v); chk("ram_alias", v, 32'h11AA_3344);
    wr(32'h10, 32'hFFFF_FFFF, 4'h0);
    rd(32'h10, v); chk("ram_be0", v, 32'h11AA_3344);
    wr(32'hFFFF_0010, 32'h1234_5678, 4'hF);
    rd(32'hFFFF_0010, v); chk("mmio_other", v, 32'h0);

    for (int i = 0; i < 5; i++) begin
      wr(TXD, 32'h41 + i, 4'h1);
    end
    rd(STS, v); chk("ovf_status", v, 32'h45);
    rd(TXD, v); chk("txdata_read0", v, 32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", {23'b0, tx_valid, tx_data}, 32'h141 + i);
      tick();
    end
    chk("ovf_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    rd(STS, v); chk("ovf_sticky", v, 32'h6);
    wr(STS, 32'h4, 4'h1);
    rd(STS, v); chk("ovf_clear", v, 32'h2);

    for (int i = 0; i < 4; i++) begin
      wr(TXD, 32'h51 + i, 4'h1);
    end
    tx_ready = 1'b1;
    wr(TXD, 32'h55, 4'h1);
    tx_ready = 1'b0;
    rd(STS, v); chk("full_pushpop", v, 32'h41);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_drain", {23'b0, tx_valid, tx_data}, 32'h152 + i);
      tick();
    end
    chk("full_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    wr(TXD, 32'h61, 4'h1);
    tx_ready = 1'b1;
    wr(TXD, 32'h62, 4'h1);
    tx_ready = 1'b0;
    rd(STS, v); chk("one_pushpop_sts", v, 32'h10);
    chk("one_pushpop_head", {24'b0, tx_data}, 32'h62);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;

    wr(MTM, 32'hFFFF_FFFE, 4'h0);
    rd(MTM, v); chk("wrap0", v, 32'hFFFF_FFFE);
    tick();
    rd(MTM, v); chk("wrap1", v, 32'hFFFF_FFFF);
    tick();
    rd(MTM, v); chk("wrap2", v, 32'h0);

    for (int i = 0; i < 3; i++) begin
      wr(TXD, 32'h71 + i, 4'h1);
    end
    rd(STS, v); chk("q3_status", v, 32'h30);
    tx_ready = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tx_ready = 1'b0;
    chk("mrst_tx_valid", {31'b0, tx_valid}, 32'h0);
    rd(STS, v); chk("mrst_status", v, 32'h2);
    rd(MTM, v); chk("mrst_mtime", v, 32'h0);
    chk("mrst_irq", {31'b0, timer_irq}, 32'h0);
    rd(32'h10, v); chk("mrst_ram", v, 32'h11AA_3344);

    wr(MCMP, 32'd20, 4'hF);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      rd(MTM, v);
      if (v == 32'd20) found = 1'b1;
      else tick();
    end
    chk("cmp_reach20", {31'b0, found}, 32'h1);
    chk("cmp_irq_pre", {31'b0, timer_irq}, 32'h0);
    tick();
    chk("cmp_irq_rise", {31'b0, timer_irq}, 32'h1);
    wr(MCMP, 32'hFFFF_FFFF, 4'hF);
    chk("cmp_irq_hold", {31'b0, timer_irq}, 32'h1);
    tick();
    chk("cmp_irq_drop", {31'b0, timer_irq}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
